// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480 @ 60 Hz timing constants.
// Used by vga_axis_counter and vga_timing_gen.
package vga_pkg;

   localparam int VGA_H_VISIBLE = 32'd640;
   localparam int VGA_H_FP      = 32'd16;
   localparam int VGA_H_SYNC    = 32'd96;
   localparam int VGA_H_BP      = 32'd48;
   localparam int VGA_V_VISIBLE = 32'd480;
   localparam int VGA_V_FP      = 32'd10;
   localparam int VGA_V_SYNC    = 32'd2;
   localparam int VGA_V_BP      = 32'd33;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef logic [9:0] vga_coord_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vga_state_e;

   // Inclusive range test used for the sync pulse windows.
   function automatic logic in_span(input vga_coord_t v, input vga_coord_t lo, input vga_coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter: counts 0..TERMINAL while enabled, wrapping to 0.
// Exposes the next count so the parent can register decodes in step with it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter vga_coord_t TERMINAL = 10'd799
)
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   output vga_coord_t o_count,
   output vga_coord_t o_count_next,
   output logic       o_wrap
);

   vga_coord_t r_count;
   vga_coord_t w_count_next;
   logic       w_wrap;

   // Next-count and terminal-wrap decode.
   always_comb begin
      w_count_next = r_count;
      w_wrap       = 1'b0;
      if (!i_reset_n) begin
         w_count_next = 10'd0;
      end else if (i_en) begin
         if (r_count == TERMINAL) begin
            w_count_next = 10'd0;
            w_wrap       = 1'b1;
         end else begin
            w_count_next = r_count + 10'd1;
         end
      end else begin
         w_count_next = r_count;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_count <= 10'd0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign o_count      = r_count;
   assign o_count_next = w_count_next;
   assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, display enable, syncs and strobes.
// Optional frame index counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
)
(
   input  logic        vga_clk,
   input  logic        reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        line_start,
`ifdef VGA_FRAME_COUNT_EN
   output logic        frame_start,
   output logic [15:0] frame_count
`else
   output logic        frame_start
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam vga_coord_t C_H_LAST  = vga_coord_t'(H_TOTAL - 1);
   localparam vga_coord_t C_V_LAST  = vga_coord_t'(V_TOTAL - 1);
   localparam vga_coord_t C_H_VIS   = vga_coord_t'(H_VISIBLE);
   localparam vga_coord_t C_V_VIS   = vga_coord_t'(V_VISIBLE);
   localparam vga_coord_t C_HS_LO   = vga_coord_t'(H_VISIBLE + H_FP);
   localparam vga_coord_t C_HS_HI   = vga_coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam vga_coord_t C_VS_LO   = vga_coord_t'(V_VISIBLE + V_FP);
   localparam vga_coord_t C_VS_HI   = vga_coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

   vga_state_e r_state;
   vga_state_e w_state_next;

   logic       w_h_en;
   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_line_next;
   logic       w_frame_next;
   vga_coord_t w_h_count;
   vga_coord_t w_v_count;
   vga_coord_t w_h_next;
   vga_coord_t w_v_next;

   logic       r_blank;
   logic       r_hs;
   logic       r_vs;
   logic       r_line_start;
   logic       r_frame_start;

   vga_axis_counter #(.TERMINAL(C_H_LAST)) u_h_axis (
      .i_clk        (vga_clk),
      .i_reset_n    (reset_n),
      .i_en         (w_h_en),
      .o_count      (w_h_count),
      .o_count_next (w_h_next),
      .o_wrap       (w_h_wrap)
   );

   vga_axis_counter #(.TERMINAL(C_V_LAST)) u_v_axis (
      .i_clk        (vga_clk),
      .i_reset_n    (reset_n),
      .i_en         (w_h_wrap),
      .o_count      (w_v_count),
      .o_count_next (w_v_next),
      .o_wrap       (w_v_wrap)
   );

   // State register: any low reset_n sample returns to IDLE.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, counter enable and strobe decode; leaving IDLE presents (0,0) as a fresh frame.
   always_comb begin
      w_state_next = r_state;
      w_h_en       = 1'b0;
      w_line_next  = 1'b0;
      w_frame_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_RUN;
            w_line_next  = 1'b1;
            w_frame_next = 1'b1;
         end
         ST_RUN: begin
            w_state_next = ST_RUN;
            w_h_en       = 1'b1;
            w_line_next  = w_h_wrap;
            w_frame_next = w_v_wrap;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Decodes are taken from the counters' next values so they land on the same edge as DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_blank       <= 1'b0;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_blank       <= (w_h_next < C_H_VIS) && (w_v_next < C_V_VIS);
         r_hs          <= ~in_span(w_h_next, C_HS_LO, C_HS_HI);
         r_vs          <= ~in_span(w_v_next, C_VS_LO, C_VS_HI);
         r_line_start  <= w_line_next;
         r_frame_start <= w_frame_next;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] r_frame_count;

   // Frame index: the frame begun out of reset is index 0, later frames step by one.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_frame_count <= 16'd0;
      end else if ((r_state == ST_RUN) && w_v_wrap) begin
         r_frame_count <= r_frame_count + 16'd1;
      end else begin
         r_frame_count <= r_frame_count;
      end
   end

   assign frame_count = r_frame_count;
`endif

   assign DrawX       = w_h_count;
   assign DrawY       = w_v_count;
   assign blank       = r_blank;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule
